// File: rtl/fan_pwm_timebase_pkg.sv
// rtl/fan_pwm_timebase_pkg.sv - shared widths and timing constants for the fan timebase
package fan_pwm_timebase_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;
   localparam int PWM_BITS_DEFAULT  = 12;
   localparam int PWM_PERIOD        = 4095;
   // 100 MHz / 50000 gives the 2 kHz fan-controller processing rate
   localparam int FAN_PROC_DIVIDER  = 50000;

   function automatic int pwm_period_for(input int bits);
      return (1 << bits) - 1;
   endfunction

endpackage

// File: rtl/fan_clk_div_unit.sv
// rtl/fan_clk_div_unit.sv - programmable clock-enable divider with square-wave and tick outputs
module fan_clk_div_unit
   import fan_pwm_timebase_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [DIV_WIDTH-1:0] divider_in,
   output logic                 div_clk_out,
   output logic                 div_tick_out
);

   logic [DIV_WIDTH-1:0] div_cnt;
   logic [DIV_WIDTH-1:0] n_eff;
   logic [DIV_WIDTH-1:0] half;
   logic [DIV_WIDTH-1:0] last;
   logic                 wrap;

   always_comb begin
      n_eff = (divider_in == '0) ? DIV_WIDTH'(1) : divider_in;
      half  = n_eff >> 1;
      last  = n_eff - DIV_WIDTH'(1);
      // >= rather than == so a live decrease below the current count wraps at once
      wrap  = (div_cnt >= last);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         div_cnt      <= '0;
         div_tick_out <= 1'b0;
         div_clk_out  <= 1'b0;
      end else begin
         div_cnt      <= wrap ? '0 : div_cnt + DIV_WIDTH'(1);
         div_tick_out <= (div_cnt == '0);
         div_clk_out  <= (div_cnt < half);
      end
   end

endmodule

// File: rtl/fan_pwm_timebase.sv
// rtl/fan_pwm_timebase.sv - fan timing core: clock-enable divider plus 12-bit PWM generator
module fan_pwm_timebase
   import fan_pwm_timebase_pkg::*;
#(
   parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT,
   parameter int PWM_BITS  = PWM_BITS_DEFAULT
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [DIV_WIDTH-1:0] divider_in,
   input  logic [PWM_BITS-1:0]  val_in,
   output logic                 div_clk_out,
   output logic                 div_tick_out,
   output logic                 pwm_out,
   output logic                 pwm_period_out
);

   localparam int PERIOD = pwm_period_for(PWM_BITS);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] duty_reg;
   logic [PWM_BITS-1:0] duty_eff;
   logic                at_start;
   logic                at_last;

   fan_clk_div_unit #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_div (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .divider_in   (divider_in),
      .div_clk_out  (div_clk_out),
      .div_tick_out (div_tick_out)
   );

   // Period start uses val_in directly so a new duty is honoured without a one-period lag;
   // the rest of the period runs from the captured copy to stay glitch-free.
   always_comb begin
      at_start = (pwm_cnt == '0);
      at_last  = (pwm_cnt == PWM_BITS'(PERIOD - 1));
      duty_eff = at_start ? val_in : duty_reg;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pwm_cnt        <= '0;
         duty_reg       <= '0;
         pwm_out        <= 1'b0;
         pwm_period_out <= 1'b0;
      end else begin
         pwm_cnt        <= at_last ? '0 : pwm_cnt + PWM_BITS'(1);
         if (at_start) begin
            duty_reg <= val_in;
         end
         pwm_out        <= (pwm_cnt < duty_eff);
         pwm_period_out <= at_start;
      end
   end

endmodule

// File: tb/tb_fan_pwm_timebase.sv
// tb/tb_fan_pwm_timebase.sv - self-checking bench for fan_pwm_timebase
module tb_fan_pwm_timebase;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] divider_in;
   logic [11:0] val_in;
   logic        div_clk_out;
   logic        div_tick_out;
   logic        pwm_out;
   logic        pwm_period_out;

   int n_cmp  = 0;
   int n_fail = 0;

   // behavioural model state: divider position and cycles since reset release
   int  m_dpos  = 0;
   int  m_t     = 0;
   int  m_duty  = 0;
   logic e_tick, e_dclk, e_pwm, e_per;
   logic o_tick, o_dclk, o_pwm, o_per;

   fan_pwm_timebase dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .divider_in     (divider_in),
      .val_in         (val_in),
      .div_clk_out    (div_clk_out),
      .div_tick_out   (div_tick_out),
      .pwm_out        (pwm_out),
      .pwm_period_out (pwm_period_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check_bit(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_num(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // one clock: predict outputs from the rules, take the edge, compare
   task automatic cyc();
      int neff;
      int ppos;
      if (rst_in) begin
         m_dpos = 0; m_t = 0; m_duty = 0;
         e_tick = 0; e_dclk = 0; e_pwm = 0; e_per = 0;
      end else begin
         neff   = (divider_in == 0) ? 1 : int'(divider_in);
         e_tick = (m_dpos == 0);
         e_dclk = (m_dpos < neff / 2);
         m_dpos = (m_dpos >= neff - 1) ? 0 : m_dpos + 1;
         ppos   = m_t % 4095;
         if (ppos == 0) m_duty = int'(val_in);
         e_pwm  = (ppos < m_duty);
         e_per  = (ppos == 0);
         m_t++;
      end
      @(posedge clk_in);
      #1;
      o_tick = div_tick_out;
      o_dclk = div_clk_out;
      o_pwm  = pwm_out;
      o_per  = pwm_period_out;
      check_bit("div_tick_out", o_tick, e_tick);
      check_bit("div_clk_out", o_dclk, e_dclk);
      check_bit("pwm_out", o_pwm, e_pwm);
      check_bit("pwm_period_out", o_per, e_per);
   endtask

   task automatic wait_strobe();
      int ok = 0;
      for (int i = 0; i < 5000; i++) begin
         cyc();
         if (o_per) begin
            ok = 1;
            break;
         end
      end
      check_num("strobe_wait", ok, 1);
   endtask

   // one PWM period from its strobe; optionally change val_in when the counter reaches change_at
   task automatic measure(input int change_at, input int new_val, output int hi, output int st);
      wait_strobe();
      hi = int'(o_pwm);
      st = int'(o_per);
      for (int i = 1; i < 4095; i++) begin
         if (i == change_at) val_in = 12'(new_val);
         cyc();
         hi += int'(o_pwm);
         st += int'(o_per);
      end
   endtask

   initial begin
      logic [7:0] pat_dclk;
      logic [7:0] pat_tick;
      int hi, st, tk, ok;

      rst_in = 1; divider_in = 4; val_in = 0;
      cyc(); cyc();
      check_num("reset_outputs", {o_tick, o_dclk, o_pwm, o_per}, 0);

      // divider_in = 4
      rst_in = 0;
      pat_dclk = 8'b00110011;
      pat_tick = 8'b00010001;
      for (int i = 0; i < 8; i++) begin
         cyc();
         check_bit("div4_clk_pattern", o_dclk, pat_dclk[i]);
         check_bit("div4_tick_pattern", o_tick, pat_tick[i]);
      end

      // divider_in = 5: high 2, low 3
      divider_in = 5;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (o_tick) begin ok = 1; break; end
      end
      check_num("div5_tick_wait", ok, 1);
      hi = int'(o_dclk); tk = int'(o_tick);
      for (int i = 1; i < 5; i++) begin
         cyc();
         hi += int'(o_dclk); tk += int'(o_tick);
      end
      check_num("div5_high_cycles", hi, 2);
      check_num("div5_ticks", tk, 1);

      // divider_in = 1 and 0 behave identically
      for (int d = 1; d >= 0; d--) begin
         divider_in = 32'(d);
         cyc(); cyc();
         hi = 0; tk = 0;
         for (int i = 0; i < 10; i++) begin
            cyc();
            hi += int'(o_dclk); tk += int'(o_tick);
         end
         check_num("div01_ticks", tk, 10);
         check_num("div01_clk_high", hi, 0);
      end

      // 10 -> 3 while the count sits at 7
      rst_in = 1; divider_in = 10;
      cyc();
      rst_in = 0;
      for (int i = 0; i < 7; i++) cyc();
      divider_in = 3;
      cyc();
      check_bit("div_change_cnt7_tick", o_tick, 1'b0);
      cyc();
      check_bit("div_change_wrap_tick", o_tick, 1'b1);
      tk = 1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         tk += int'(o_tick);
      end
      check_num("div3_ticks_9cyc", tk, 3);

      // PWM duty extremes and midpoint
      val_in = 0;
      measure(-1, 0, hi, st);
      check_num("pwm0_high", hi, 0);
      check_num("pwm0_strobes", st, 1);
      val_in = 4095;
      measure(-1, 0, hi, st);
      check_num("pwm4095_high", hi, 4095);
      val_in = 2048;
      measure(-1, 0, hi, st);
      check_num("pwm2048_high", hi, 2048);
      check_num("pwm2048_strobes", st, 1);

      // mid-period change 100 -> 3000 at count 50
      val_in = 100;
      measure(50, 3000, hi, st);
      check_num("pwm_change_cur_high", hi, 100);
      measure(-1, 0, hi, st);
      check_num("pwm_change_next_high", hi, 3000);

      // one-cycle reset pulse mid-period
      val_in = 1000;
      wait_strobe();
      for (int i = 0; i < 500; i++) cyc();
      rst_in = 1;
      cyc();
      check_num("midreset_outputs", {o_tick, o_dclk, o_pwm, o_per}, 0);
      rst_in = 0;
      cyc();
      check_bit("restart_tick", o_tick, 1'b1);
      check_bit("restart_period", o_per, 1'b1);
      hi = int'(o_pwm);
      for (int i = 1; i < 4095; i++) begin
         cyc();
         hi += int'(o_pwm);
      end
      check_num("restart_pwm_high", hi, 1000);
      cyc();
      check_bit("restart_next_period", o_per, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
